// File: rtl/alu_seq_accum_pkg.sv
// Shared opcode and FSM state types for the sequential accumulator ALU.
// Opcode values match the front-panel switch encoding used by the board top.
package alu_seq_accum_pkg;

   typedef enum logic [2:0] {
      OpInc   = 3'd0,
      OpAdd   = 3'd1,
      OpSub   = 3'd2,
      OpXoror = 3'd3,
      OpAny   = 3'd4,
      OpEcho  = 3'd5,
      OpShl   = 3'd6,
      OpMul   = 3'd7
   } alu_op_e;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StMul  = 1'b1
   } alu_state_e;

   localparam int unsigned DefaultWidth = 4;

endpackage

// File: rtl/alu_seq_accum_mul.sv
// Iterative shift-add multiplier: one partial product per step, WIDTH steps per product.
// product_o is the accumulator value after the current step, valid when last_o is high.
module alu_seq_accum_mul #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] product_o,
   output logic               last_o
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CntW-1:0]    cnt_q;

   logic [2*WIDTH-1:0] partial;
   logic [2*WIDTH-1:0] acc_d;

   always_comb begin
      partial   = mplier_q[0] ? mcand_q : '0;
      acc_d     = acc_q + partial;
      product_o = acc_d;
      last_o    = (cnt_q == CntW'(WIDTH - 1));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (load_i) begin
         mcand_q  <= {{WIDTH{1'b0}}, a_i};
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (step_i) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/alu_seq_accum.sv
// Clocked ALU with a 2*WIDTH result register; B can be fed back from the result for
// accumulation. Single-cycle ops complete on the start edge, multiply iterates WIDTH cycles.
module alu_seq_accum
   import alu_seq_accum_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         func,
   input  logic               use_reg,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result,
   output logic               busy,
   output logic               done
);

   alu_state_e         state_q, state_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               done_q, done_d;

   alu_op_e            op;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] alu_res;

   logic               mul_load;
   logic               mul_step;
   logic [2*WIDTH-1:0] mul_product;
   logic               mul_last;

   // B is taken from the result register as it stood before this edge.
   assign op_b = use_reg ? result_q[WIDTH-1:0] : b;
   assign op   = alu_op_e'(func);

   always_comb begin
      sum     = {1'b0, a} + {1'b0, op_b};
      diff    = {1'b0, a} - {1'b0, op_b};
      alu_res = '0;
      unique case (op)
         OpInc:   alu_res[WIDTH-1:0] = a + WIDTH'(1);
         OpAdd:   alu_res[WIDTH:0] = sum;
         // Bit WIDTH of the extended difference is the borrow.
         OpSub:   alu_res[WIDTH:0] = diff;
         OpXoror: alu_res = {a | op_b, a ^ op_b};
         OpAny:   alu_res[1:0] = {1'b0, |a} + {1'b0, |op_b};
         OpEcho:  alu_res = {a, op_b};
         OpShl:   alu_res = {{WIDTH{1'b0}}, op_b} << a;
         OpMul:   alu_res = '0;
         default: alu_res = '0;
      endcase
   end

   alu_seq_accum_mul #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk_i    (clk),
      .reset_i  (reset),
      .load_i   (mul_load),
      .step_i   (mul_step),
      .a_i      (a),
      .b_i      (op_b),
      .product_o(mul_product),
      .last_o   (mul_last)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      done_d   = 1'b0;
      mul_load = 1'b0;
      mul_step = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (op == OpMul) begin
                  mul_load = 1'b1;
                  state_d  = StMul;
               end else begin
                  result_d = alu_res;
                  done_d   = 1'b1;
               end
            end
         end
         StMul: begin
            mul_step = 1'b1;
            if (mul_last) begin
               result_d = mul_product;
               done_d   = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = (state_q == StMul);

endmodule

// File: tb/tb_alu_seq_accum.sv
// Directed bench for alu_seq_accum at WIDTH=4 with hand-computed expected results.
module tb_alu_seq_accum;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] func = 3'd0;
   logic       use_reg = 1'b0;
   logic [3:0] a = 4'h0;
   logic [3:0] b = 4'h0;
   logic [7:0] result;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_seq_accum #(
      .WIDTH(4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .func   (func),
      .use_reg(use_reg),
      .a      (a),
      .b      (b),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single-cycle op: pulse start, check result and one-cycle done.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [3:0] av,
                         input logic [3:0] bv, input logic ur, input logic [7:0] exp);
      func = f; a = av; b = bv; use_reg = ur; start = 1'b1;
      tick();
      start = 1'b0; use_reg = 1'b0;
      check({tag, " result"}, 32'(result), 32'(exp));
      check({tag, " done"}, 32'(done), 32'd1);
      tick();
      check({tag, " done low"}, 32'(done), 32'd0);
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      check("reset result", 32'(result), 32'h00);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);

      run_op("add F+1", 3'd1, 4'hF, 4'h1, 1'b0, 8'h10);
      run_op("sub 2-5", 3'd2, 4'h2, 4'h5, 1'b0, 8'h1D);
      run_op("sub 5-2", 3'd2, 4'h5, 4'h2, 1'b0, 8'h03);
      run_op("inc F", 3'd0, 4'hF, 4'h0, 1'b0, 8'h00);
      run_op("any 0,3", 3'd4, 4'h0, 4'h3, 1'b0, 8'h01);
      run_op("echo 3,5", 3'd5, 4'h3, 4'h5, 1'b0, 8'h35);
      run_op("xoror C,A", 3'd3, 4'hC, 4'hA, 1'b0, 8'hE6);

      // MUL F*F: start edge, then four iteration edges with a stray start in between.
      func = 3'd7; a = 4'hF; b = 4'hF; start = 1'b1;
      tick();
      start = 1'b0;
      check("mul busy e1", 32'(busy), 32'd1);
      check("mul done e1", 32'(done), 32'd0);
      func = 3'd1; a = 4'h1; b = 4'h1; start = 1'b1;
      tick();
      start = 1'b0;
      check("mul busy e2", 32'(busy), 32'd1);
      check("mul held e2", 32'(result), 32'hE6);
      tick();
      check("mul busy e3", 32'(busy), 32'd1);
      check("mul done e3", 32'(done), 32'd0);
      tick();
      check("mul busy e4", 32'(busy), 32'd1);
      check("mul held e4", 32'(result), 32'hE6);
      tick();
      check("mul result", 32'(result), 32'hE1);
      check("mul done e5", 32'(done), 32'd1);
      check("mul busy e5", 32'(busy), 32'd0);
      tick();
      check("mul done low", 32'(done), 32'd0);
      check("mul hold", 32'(result), 32'hE1);

      // Accumulate through the result feedback path.
      run_op("seed 1+2", 3'd1, 4'h1, 4'h2, 1'b0, 8'h03);
      run_op("acc +2", 3'd1, 4'h2, 4'hF, 1'b1, 8'h05);
      run_op("acc +2 again", 3'd1, 4'h2, 4'hF, 1'b1, 8'h07);

      // Reset during the second MUL cycle aborts without a done pulse.
      func = 3'd7; a = 4'hF; b = 4'hF; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort result", 32'(result), 32'h00);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      tick();
      check("abort no done", 32'(done), 32'd0);
      check("abort busy later", 32'(busy), 32'd0);
      run_op("add 1+1", 3'd1, 4'h1, 4'h1, 1'b0, 8'h02);

      run_op("shl 1<<7", 3'd6, 4'h7, 4'h1, 1'b0, 8'h80);
      run_op("shl 1<<8", 3'd6, 4'h8, 4'h1, 1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
